// File: rtl/core_pc_gen.sv
// core_pc_gen: front-end PC generator feeding instruction fetch.
// It produces one 8-byte, two-slot fetch packet per cycle. The packet PC
// advances sequentially, moves to the predicted target on a BTB hit, or
// loads the backend redirect target.
// Build option CORE_PC_GEN_BTB_EN: when defined, a direct-mapped BTB with
// 2-bit counters supplies per-slot predictions and learns from branch
// resolution. When undefined, fetch is purely sequential and upd_* is ignored.
module core_pc_gen #(
  parameter logic [31:0] RESET_PC  = 32'h1c00_0000,
  parameter int          BTB_DEPTH = 64,
  parameter int          BTB_TAG_W = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rst_jmp_i,
  input  logic [31:0] rst_target_i,
  input  logic        stall_i,
  output logic [31:0] pc_o,
  output logic [31:0] npc_o,
  output logic [1:0]  valid_o,
  output logic [1:0]  pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i
);

  logic [31:0] pc_r;
  logic [31:0] npc_s;
  logic [31:0] seq_pc_s;
  logic        unused_s;

  // Sequential fall-through; the 29-bit add wraps 32'hffff_fff8 to 0.
  assign seq_pc_s = {pc_r[31:3] + 29'd1, 3'b000};

  // Only part of the update address and target feed the BTB, and none of
  // it does when the BTB is not built.
  assign unused_s = ^{upd_valid_i, upd_taken_i, upd_pc_i, upd_target_i};

`ifdef CORE_PC_GEN_BTB_EN
  localparam int IDX_W   = $clog2(BTB_DEPTH);
  localparam int TAG_LSB = 3 + IDX_W;

  // Saturating increment of a 2-bit direction counter.
  function automatic logic [1:0] cnt_inc(input logic [1:0] cnt);
    if (cnt == 2'b11) begin
      cnt_inc = 2'b11;
    end else begin
      cnt_inc = cnt + 2'b01;
    end
  endfunction

  // Saturating decrement of a 2-bit direction counter.
  function automatic logic [1:0] cnt_dec(input logic [1:0] cnt);
    if (cnt == 2'b00) begin
      cnt_dec = 2'b00;
    end else begin
      cnt_dec = cnt - 2'b01;
    end
  endfunction

  // BTB storage: only the valid bits need reset; the payload is qualified by them.
  logic [BTB_DEPTH-1:0] btb_v_r;
  logic [BTB_TAG_W-1:0] btb_tag_r  [BTB_DEPTH];
  logic                 btb_slot_r [BTB_DEPTH];
  logic [29:0]          btb_tgt_r  [BTB_DEPTH];
  logic [1:0]           btb_cnt_r  [BTB_DEPTH];

  logic [IDX_W-1:0]     rd_idx_s;
  logic [BTB_TAG_W-1:0] rd_tag_s;
  logic                 hit_s;
  logic                 taken_s;

  logic [IDX_W-1:0]     upd_idx_s;
  logic [BTB_TAG_W-1:0] upd_tag_s;
  logic                 upd_match_s;

  // Lookup on the current packet. The slot check rejects a branch that sits
  // before the start slot of a packet entered at its upper half.
  assign rd_idx_s = pc_r[3 +: IDX_W];
  assign rd_tag_s = pc_r[TAG_LSB +: BTB_TAG_W];
  assign hit_s    = btb_v_r[rd_idx_s]
                 && (btb_tag_r[rd_idx_s] == rd_tag_s)
                 && (btb_slot_r[rd_idx_s] >= pc_r[2]);
  assign taken_s  = hit_s && btb_cnt_r[rd_idx_s][1];

  // Training address decode; a match needs the exact slot as well.
  assign upd_idx_s   = upd_pc_i[3 +: IDX_W];
  assign upd_tag_s   = upd_pc_i[TAG_LSB +: BTB_TAG_W];
  assign upd_match_s = btb_v_r[upd_idx_s]
                    && (btb_tag_r[upd_idx_s] == upd_tag_s)
                    && (btb_slot_r[upd_idx_s] == upd_pc_i[2]);

  // Per-slot valid, prediction and next PC from the lookup result.
  always_comb begin
    valid_o = pc_r[2] ? 2'b10 : 2'b11;
    if (taken_s) begin
      pred_target_o = {btb_tgt_r[rd_idx_s], 2'b00};
      npc_s         = {btb_tgt_r[rd_idx_s], 2'b00};
      if (btb_slot_r[rd_idx_s]) begin
        pred_taken_o = 2'b10;
      end else begin
        pred_taken_o = 2'b01;
        valid_o[1]   = 1'b0;
      end
    end else begin
      pred_taken_o  = 2'b00;
      pred_target_o = 32'h0000_0000;
      npc_s         = seq_pc_s;
    end
  end

  // Valid bits: cleared on reset, set when a taken miss allocates an entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btb_v_r <= {BTB_DEPTH{1'b0}};
    end else if (upd_valid_i && !upd_match_s && upd_taken_i) begin
      btb_v_r[upd_idx_s] <= 1'b1;
    end
  end

  // Entry payload training; a taken miss replaces whatever occupied the index.
  always_ff @(posedge clk) begin
    if (rst_n && upd_valid_i) begin
      if (upd_match_s) begin
        if (upd_taken_i) begin
          btb_cnt_r[upd_idx_s] <= cnt_inc(btb_cnt_r[upd_idx_s]);
          btb_tgt_r[upd_idx_s] <= upd_target_i[31:2];
        end else begin
          btb_cnt_r[upd_idx_s] <= cnt_dec(btb_cnt_r[upd_idx_s]);
        end
      end else if (upd_taken_i) begin
        btb_tag_r[upd_idx_s]  <= upd_tag_s;
        btb_slot_r[upd_idx_s] <= upd_pc_i[2];
        btb_tgt_r[upd_idx_s]  <= upd_target_i[31:2];
        btb_cnt_r[upd_idx_s]  <= 2'b10;
      end
    end
  end
`else
  // Sequential-only fetch: no predictions, start slot alone sets validity.
  always_comb begin
    valid_o       = pc_r[2] ? 2'b10 : 2'b11;
    pred_taken_o  = 2'b00;
    pred_target_o = 32'h0000_0000;
    npc_s         = seq_pc_s;
  end
`endif

  // PC register: redirect beats stall; a redirect target may be unaligned.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r <= RESET_PC;
    end else if (rst_jmp_i) begin
      pc_r <= rst_target_i;
    end else if (!stall_i) begin
      pc_r <= npc_s;
    end
  end

  assign pc_o  = pc_r;
  assign npc_o = npc_s;

endmodule

// File: tb/tb_core_pc_gen.sv
// tb_core_pc_gen: directed, table-driven bench for core_pc_gen.
// Expectations are written for the BTB build; in the sequential-only build
// (CORE_PC_GEN_BTB_EN undefined) predictions are expected to stay off.
module tb_core_pc_gen;

`ifdef CORE_PC_GEN_BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        rst_jmp_i;
  logic [31:0] rst_target_i;
  logic        stall_i;
  logic [31:0] pc_o;
  logic [31:0] npc_o;
  logic [1:0]  valid_o;
  logic [1:0]  pred_taken_o;
  logic [31:0] pred_target_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;

  int n_checks;
  int n_fail;

  typedef struct {
    logic        jmp;
    logic [31:0] tgt;
    logic        stall;
    logic [31:0] exp_pc;
    logic [1:0]  exp_valid;
  } vec_t;

  vec_t vecs [12];

  core_pc_gen dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rst_jmp_i     (rst_jmp_i),
    .rst_target_i  (rst_target_i),
    .stall_i       (stall_i),
    .pc_o          (pc_o),
    .npc_o         (npc_o),
    .valid_o       (valid_o),
    .pred_taken_o  (pred_taken_o),
    .pred_target_o (pred_target_o),
    .upd_valid_i   (upd_valid_i),
    .upd_pc_i      (upd_pc_i),
    .upd_taken_i   (upd_taken_i),
    .upd_target_i  (upd_target_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Check a fetched packet; pred/tgt are the hand-computed BTB-build values.
  task automatic check_fetch(input string nm, input logic [31:0] epc,
                             input logic [1:0] epred_btb, input logic [31:0] etgt_btb);
    logic [1:0]  ep;
    logic [31:0] et;
    logic [1:0]  ev;
    logic [31:0] en;
    ep = BTB_ON ? epred_btb : 2'b00;
    et = (ep != 2'b00) ? etgt_btb : 32'h0;
    ev = epc[2] ? 2'b10 : 2'b11;
    if (ep == 2'b01) ev = 2'b01;
    en = (ep != 2'b00) ? etgt_btb : {epc[31:3] + 29'd1, 3'b000};
    chk({nm, ".pc"}, pc_o, epc);
    chk({nm, ".valid"}, {30'd0, valid_o}, {30'd0, ev});
    chk({nm, ".pred"}, {30'd0, pred_taken_o}, {30'd0, ep});
    chk({nm, ".tgt"}, pred_target_o, et);
    chk({nm, ".npc"}, npc_o, en);
  endtask

  task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    upd_valid_i  = 1'b1;
    upd_pc_i     = pc;
    upd_taken_i  = taken;
    upd_target_i = tgt;
    step();
    upd_valid_i  = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc);
    rst_jmp_i    = 1'b1;
    rst_target_i = pc;
    step();
    rst_jmp_i    = 1'b0;
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    rst_jmp_i    = 1'b0;
    rst_target_i = 32'h0;
    stall_i      = 1'b0;
    upd_valid_i  = 1'b0;
    upd_pc_i     = 32'h0;
    upd_taken_i  = 1'b0;
    upd_target_i = 32'h0;

    //                jmp   target         stall  exp_pc         valid
    vecs[0]  = '{1'b0, 32'h0,          1'b0, 32'h1c00_0008, 2'b11};
    vecs[1]  = '{1'b0, 32'h0,          1'b0, 32'h1c00_0010, 2'b11};
    vecs[2]  = '{1'b1, 32'h1c00_0104,  1'b1, 32'h1c00_0104, 2'b10};
    vecs[3]  = '{1'b0, 32'h0,          1'b0, 32'h1c00_0108, 2'b11};
    vecs[4]  = '{1'b0, 32'h0,          1'b1, 32'h1c00_0108, 2'b11};
    vecs[5]  = '{1'b0, 32'h0,          1'b1, 32'h1c00_0108, 2'b11};
    vecs[6]  = '{1'b0, 32'h0,          1'b1, 32'h1c00_0108, 2'b11};
    vecs[7]  = '{1'b0, 32'h0,          1'b1, 32'h1c00_0108, 2'b11};
    vecs[8]  = '{1'b0, 32'h0,          1'b1, 32'h1c00_0108, 2'b11};
    vecs[9]  = '{1'b0, 32'h0,          1'b0, 32'h1c00_0110, 2'b11};
    vecs[10] = '{1'b1, 32'h1c00_0003,  1'b0, 32'h1c00_0003, 2'b11};
    vecs[11] = '{1'b0, 32'h0,          1'b0, 32'h1c00_0008, 2'b11};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_fetch("reset", 32'h1c00_0000, 2'b00, 32'h0);

    // Sequential fetch, redirect over stall, 5-cycle stall, unaligned redirect.
    for (int i = 0; i < 12; i++) begin
      rst_jmp_i    = vecs[i].jmp;
      rst_target_i = vecs[i].tgt;
      stall_i      = vecs[i].stall;
      step();
      chk($sformatf("vec%0d.pc", i), pc_o, vecs[i].exp_pc);
      chk($sformatf("vec%0d.valid", i), {30'd0, valid_o}, {30'd0, vecs[i].exp_valid});
      chk($sformatf("vec%0d.pred", i), {30'd0, pred_taken_o}, 32'd0);
    end
    rst_jmp_i = 1'b0;
    stall_i   = 1'b0;

    // First-pass taken training on slot 0.
    train(32'h1c00_0020, 1'b1, 32'h1c00_0400);
    fetch(32'h1c00_0020);
    check_fetch("train_hit", 32'h1c00_0020, 2'b01, 32'h1c00_0400);
    step();
    chk("follow.pc", pc_o, BTB_ON ? 32'h1c00_0400 : 32'h1c00_0028);
    fetch(32'h1c00_0024);
    check_fetch("slot0_from_slot1", 32'h1c00_0024, 2'b00, 32'h0);

    // Counter decay to 00, saturation at 00, then hysteresis.
    train(32'h1c00_0020, 1'b0, 32'h0);
    train(32'h1c00_0020, 1'b0, 32'h0);
    fetch(32'h1c00_0020);
    check_fetch("decay00", 32'h1c00_0020, 2'b00, 32'h0);
    train(32'h1c00_0020, 1'b0, 32'h0);
    train(32'h1c00_0020, 1'b1, 32'h1c00_0400);
    fetch(32'h1c00_0020);
    check_fetch("cnt01", 32'h1c00_0020, 2'b00, 32'h0);
    train(32'h1c00_0020, 1'b1, 32'h1c00_0400);
    fetch(32'h1c00_0020);
    check_fetch("cnt10", 32'h1c00_0020, 2'b01, 32'h1c00_0400);
    train(32'h1c00_0020, 1'b1, 32'h1c00_0400);
    train(32'h1c00_0020, 1'b1, 32'h1c00_0400);
    train(32'h1c00_0020, 1'b0, 32'h0);
    fetch(32'h1c00_0020);
    check_fetch("sat11", 32'h1c00_0020, 2'b01, 32'h1c00_0400);

    // Slot-1 branch: hit from either start slot.
    train(32'h1c00_0034, 1'b1, 32'h1c00_0800);
    fetch(32'h1c00_0034);
    check_fetch("slot1_hit", 32'h1c00_0034, 2'b10, 32'h1c00_0800);
    fetch(32'h1c00_0030);
    check_fetch("slot1_from0", 32'h1c00_0030, 2'b10, 32'h1c00_0800);
    // Slot-0 branch at the same index replaces it; skipped when starting at slot 1.
    train(32'h1c00_0030, 1'b1, 32'h1c00_0900);
    fetch(32'h1c00_0034);
    check_fetch("slot0_skip", 32'h1c00_0034, 2'b00, 32'h0);
    fetch(32'h1c00_0030);
    check_fetch("slot0_hit", 32'h1c00_0030, 2'b01, 32'h1c00_0900);

    // Alias: same index, different tag, replaces the old entry.
    train(32'h1c00_0220, 1'b1, 32'h1c00_0a00);
    fetch(32'h1c00_0020);
    check_fetch("alias_old", 32'h1c00_0020, 2'b00, 32'h0);
    fetch(32'h1c00_0220);
    check_fetch("alias_new", 32'h1c00_0220, 2'b01, 32'h1c00_0a00);

    // Training while stalled at the same index: lookup sees old contents.
    stall_i      = 1'b1;
    upd_valid_i  = 1'b1;
    upd_pc_i     = 32'h1c00_0220;
    upd_taken_i  = 1'b0;
    upd_target_i = 32'h0;
    #1;
    chk("prewrite.pred", {30'd0, pred_taken_o}, BTB_ON ? 32'd1 : 32'd0);
    @(negedge clk);
    upd_valid_i = 1'b0;
    check_fetch("postwrite", 32'h1c00_0220, 2'b00, 32'h0);

    // Reset in the middle of a stall reloads RESET_PC and empties the BTB.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_fetch("rst_in_stall", 32'h1c00_0000, 2'b00, 32'h0);
    stall_i = 1'b0;
    fetch(32'h1c00_0030);
    check_fetch("btb_cleared", 32'h1c00_0030, 2'b00, 32'h0);

    // Wrap-around of the sequential PC.
    fetch(32'hffff_fff8);
    step();
    chk("wrap.pc", pc_o, 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
